approx_mul_pipe: RTL and testbench

Parametrised, pipelined approximate unsigned multiplier. It generalises the fixed 8x8 four-quadrant approximate multiplier to WIDTH-bit operands split into 4-bit digits. Each digit-pair partial product uses a kernel chosen at run time per significance rank: exact, ap4 or ap2. The block sits in the datapath as a streaming multiplier with valid/ready handshakes on both sides and full-throughput backpressure.

---
 rtl/approx_mul_pkg.sv | 30 +++
 rtl/approx_ap2.sv | 23 ++
 rtl/approx_ap4.sv | 27 ++
 rtl/approx_exact4.sv | 16 +
 rtl/approx_kernel4.sv | 34 +++
 rtl/approx_mul_pipe.sv | 123 ++++++++++++
 tb/tb_approx_mul_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mul_pkg
//  Description : Shared types, kernel-select codes and the 2x2 approximate
//                building block used by the approximate multiplier slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_mul_pkg;

    // Per-rank kernel selector carried with every transaction.
    typedef logic [1:0] kern_t;

    localparam kern_t KERN_EXACT = 2'd0;
    localparam kern_t KERN_AP4   = 2'd1;
    localparam kern_t KERN_AP2   = 2'd2;
    localparam kern_t KERN_RSVD  = 2'd3;

    // 2x2 approximate product: exact except 3*3, which yields 7 so the
    // result always fits in three bits.
    function automatic logic [3:0] kmul2(input logic [1:0] a, input logic [1:0] b);
        logic [3:0] p;
        p = {2'b00, a} * {2'b00, b};
        if (a == 2'd3 && b == 2'd3) begin
            p = 4'd7;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_ap2.sv
`default_nettype none
// ============================================================================
//  Module      : approx_ap2
//  Description : 4x4 approximate multiplier that keeps the three upper 2x2
//                cross terms exactly and drops the low*low term entirely.
//  Ports       : i_a, i_b  4-bit operands
//                o_p       8-bit approximate product
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_ap2 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] w_hh, w_hl, w_lh;

    assign w_hh = {6'b000000, i_a[3:2]} * {6'b000000, i_b[3:2]};
    assign w_hl = {6'b000000, i_a[3:2]} * {6'b000000, i_b[1:0]};
    assign w_lh = {6'b000000, i_a[1:0]} * {6'b000000, i_b[3:2]};

    assign o_p = (w_hh << 4) + (w_hl << 2) + (w_lh << 2);
endmodule
`default_nettype wire

// File: rtl/approx_ap4.sv
`default_nettype none
// ============================================================================
//  Module      : approx_ap4
//  Description : 4x4 approximate multiplier built from four approximate 2x2
//                blocks (each block maps 3*3 to 7). Largest output is 175.
//  Ports       : i_a, i_b  4-bit operands
//                o_p       8-bit approximate product
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_ap4
    import approx_mul_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0] w_hh, w_hl, w_lh, w_ll;

    assign w_hh = kmul2(i_a[3:2], i_b[3:2]);
    assign w_hl = kmul2(i_a[3:2], i_b[1:0]);
    assign w_lh = kmul2(i_a[1:0], i_b[3:2]);
    assign w_ll = kmul2(i_a[1:0], i_b[1:0]);

    assign o_p = ({4'b0000, w_hh} << 4) + ({4'b0000, w_hl} << 2)
               + ({4'b0000, w_lh} << 2) +  {4'b0000, w_ll};
endmodule
`default_nettype wire

// File: rtl/approx_exact4.sv
`default_nettype none
// ============================================================================
//  Module      : approx_exact4
//  Description : Exact 4x4 unsigned multiplier kernel.
//  Ports       : i_a, i_b  4-bit operands
//                o_p       8-bit exact product
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_exact4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    assign o_p = {4'b0000, i_a} * {4'b0000, i_b};
endmodule
`default_nettype wire

// File: rtl/approx_kernel4.sv
`default_nettype none
// ============================================================================
//  Module      : approx_kernel4
//  Description : One digit-pair multiplier. Evaluates the exact, ap4 and ap2
//                kernels in parallel and selects one by kernel code.
//  Ports       : i_a, i_b  4-bit digits
//                i_sel     kernel code (reserved code behaves as exact)
//                o_p       8-bit partial product
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_kernel4
    import approx_mul_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  kern_t      i_sel,
    output logic [7:0] o_p
);
    logic [7:0] w_exact, w_ap4, w_ap2;

    approx_exact4 u_exact (.i_a(i_a), .i_b(i_b), .o_p(w_exact));
    approx_ap4    u_ap4   (.i_a(i_a), .i_b(i_b), .o_p(w_ap4));
    approx_ap2    u_ap2   (.i_a(i_a), .i_b(i_b), .o_p(w_ap2));

    always_comb begin
        o_p = w_exact;
        case (i_sel)
            KERN_AP4:              o_p = w_ap4;
            KERN_AP2:              o_p = w_ap2;
            KERN_EXACT, KERN_RSVD: o_p = w_exact;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mul_pipe
//  Description : Three-stage streaming approximate unsigned multiplier.
//                Operands are split into 4-bit digits; each digit pair uses
//                the kernel selected for its rank k = i + j.
//                S1: operands + config snapshot, S2: partial products,
//                S3: shifted sum.
//  Ports       : clk, rst_n          clock, async active-low reset
//                cfg_we, cfg_data    kernel-config write (2 bits per rank)
//                in_valid/in_ready   operand handshake, in_a / in_b
//                out_valid/out_ready result handshake, out_prod
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int                                 WIDTH       = 8,
    parameter logic [2*(2*(WIDTH/4)-1)-1:0]       DEFAULT_CFG = 6'b10_01_01
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [2*(2*(WIDTH/4)-1)-1:0]     cfg_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_a,
    input  logic [WIDTH-1:0]                 in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*WIDTH-1:0]               out_prod
);
    localparam int D   = WIDTH / 4;
    localparam int R   = 2 * D - 1;
    localparam int CW  = 2 * R;
    localparam int PW  = 2 * WIDTH;
    localparam int NPP = D * D;

    logic [CW-1:0]    r_cfg;
    logic             r_s1_valid, r_s2_valid, r_s3_valid;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    logic [CW-1:0]    r_s1_cfg;
    logic [7:0]       w_pp    [NPP];
    logic [7:0]       r_s2_pp [NPP];
    logic [PW-1:0]    w_term  [NPP];
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    r_prod;
    logic             w_s1_ready, w_s2_ready, w_s3_ready;

    // Ready chains combinationally from the output back to the input, so a
    // full pipe resumes accepting in the same cycle out_ready rises.
    assign w_s3_ready = !r_s3_valid || out_ready;
    assign w_s2_ready = !r_s2_valid || w_s3_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;

    assign in_ready  = w_s1_ready;
    assign out_valid = r_s3_valid;
    assign out_prod  = r_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= DEFAULT_CFG;
        end else if (cfg_we) begin
            r_cfg <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_s1_ready) r_s1_valid <= in_valid;
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s3_ready) r_s3_valid <= r_s2_valid;
        end
    end

    // Data registers need no reset; their valid bits qualify them. The
    // snapshot takes r_cfg before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (w_s1_ready && in_valid) begin
            r_s1_a   <= in_a;
            r_s1_b   <= in_b;
            r_s1_cfg <= r_cfg;
        end
        if (w_s2_ready) begin
            r_s2_pp <= w_pp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (w_s3_ready && r_s2_valid) begin
            r_prod <= w_sum;
        end
    end

    // One kernel per digit pair; the term for rank k is shifted by 4k. The
    // top rank shifts an 8-bit value to exactly the MSB, so nothing is lost.
    for (genvar gi = 0; gi < D; gi++) begin : g_row
        for (genvar gj = 0; gj < D; gj++) begin : g_col
            approx_kernel4 u_kern (
                .i_a   (r_s1_a[4*gi +: 4]),
                .i_b   (r_s1_b[4*gj +: 4]),
                .i_sel (r_s1_cfg[2*(gi+gj) +: 2]),
                .o_p   (w_pp[gi*D+gj])
            );
            assign w_term[gi*D+gj] = {{(PW-8){1'b0}}, r_s2_pp[gi*D+gj]} << (4*(gi+gj));
        end
    end

    always_comb begin
        w_sum = '0;
        for (int n = 0; n < NPP; n++) begin
            w_sum = w_sum + w_term[n];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_mul_pipe
//  Description : Directed self-checking bench for approx_mul_pipe at
//                WIDTH=8 and WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mul_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we;
    logic [5:0]  cfg_data;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic        out_valid, out_ready;
    logic [15:0] out_prod;

    logic        we16;
    logic [13:0] cfg16;
    logic        v16, rdy16;
    logic [15:0] a16, b16;
    logic        ov16, ordy16;
    logic [31:0] p16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [15:0] got8[$];
    logic [31:0] got16[$];
    int          st16[$];

    approx_mul_pipe #(.WIDTH(8), .DEFAULT_CFG(6'b10_01_01)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
    );

    approx_mul_pipe #(.WIDTH(16), .DEFAULT_CFG(14'b01_10_01_10_01_10_01)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we16), .cfg_data(cfg16),
        .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16),
        .out_valid(ov16), .out_ready(ordy16), .out_prod(p16)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got8.push_back(out_prod);
        if (rst_n && ov16 && ordy16) begin
            got16.push_back(p16);
            st16.push_back(cyc);
        end
    end

    // Reference 4x4 kernels expressed as corrections to the exact product.
    function automatic logic [7:0] kern_ref(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] code);
        logic [7:0] p;
        p = {4'b0000, a} * {4'b0000, b};
        if (code == 2'd1) begin
            if (a[3:2] == 2'd3 && b[3:2] == 2'd3) p = p - 8'd32;
            if (a[3:2] == 2'd3 && b[1:0] == 2'd3) p = p - 8'd8;
            if (a[1:0] == 2'd3 && b[3:2] == 2'd3) p = p - 8'd8;
            if (a[1:0] == 2'd3 && b[1:0] == 2'd3) p = p - 8'd2;
        end else if (code == 2'd2) begin
            p = p - {6'b000000, a[1:0]} * {6'b000000, b[1:0]};
        end
        return p;
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] cfg);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                s = s + ({8'h00, kern_ref(a[4*i +: 4], b[4*j +: 4], cfg[2*(i+j) +: 2])} << (4*(i+j)));
        return s;
    endfunction

    // All tasks start and end at posedge+1.
    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
            if (k == 49) begin
                n_tests++; n_fail++;
                $display("FAIL push8_timeout: in_ready stayed %b, want 1", in_ready);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic push16(input logic [15:0] a, input logic [15:0] b);
        v16 = 1'b1; a16 = a; b16 = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy16) break;
            if (k == 49) begin
                n_tests++; n_fail++;
                $display("FAIL push16_timeout: in_ready stayed %b, want 1", rdy16);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain8(input int n);
        for (int k = 0; k < 200 && got8.size() < n; k++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (got8.size() != n) begin
            n_fail++;
            $display("FAIL drain8_count: got %0d results, want %0d", got8.size(), n);
        end
    endtask

    task automatic drain16(input int n);
        for (int k = 0; k < 300 && got16.size() < n; k++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (got16.size() != n) begin
            n_fail++;
            $display("FAIL drain16_count: got %0d results, want %0d", got16.size(), n);
        end
    endtask

    task automatic write_cfg8(input logic [5:0] c);
        cfg_we = 1'b1; cfg_data = c;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got8.delete(); got16.delete(); st16.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_we = 1'b0; cfg_data = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; we16 = 1'b0; cfg16 = '0; v16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_tests++; if (out_prod !== 16'd0) begin n_fail++; $display("FAIL reset_out_prod: got %0d want 0", out_prod); end
        n_tests++; if (ov16 !== 1'b0 || rdy16 !== 1'b1 || p16 !== 32'd0) begin
            n_fail++; $display("FAIL reset_w16: got valid=%b ready=%b prod=%h want 0/1/0", ov16, rdy16, p16);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        write_cfg8(6'b00_00_00);
        got8.delete();
        push8(8'd200, 8'd100);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e0: out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e1: out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b1 || out_prod !== 16'd20000) begin
            n_fail++; $display("FAIL exact_200x100: got valid=%b prod=%0d want 1/20000", out_valid, out_prod);
        end
        @(posedge clk); #1;
        got8.delete();
        push8(8'd255, 8'd255);
        in_valid = 1'b0;
        drain8(1);
        n_tests++; if (got8.size() < 1 || got8[0] !== 16'd65025) begin
            n_fail++; $display("FAIL exact_255x255: got %0d want 65025", got8.size() > 0 ? got8[0] : 16'd0);
        end
    endtask

    task automatic test_default();
        logic [7:0]  ha [4] = '{8'd255, 8'd15, 8'd0,   8'hF0};
        logic [7:0]  hb [4] = '{8'd255, 8'd15, 8'd200, 8'h0F};
        logic [15:0] he [4] = '{16'd61071, 16'd175, 16'd0, 16'd2800};
        logic [15:0] exp_q[$];
        logic [7:0]  a, b;
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) push8(ha[k], hb[k]);
        in_valid = 1'b0;
        drain8(4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= got8.size() || got8[k] !== he[k]) begin
                n_fail++; $display("FAIL default_hand[%0d]: got %0d want %0d", k, k < got8.size() ? got8[k] : 16'd0, he[k]);
            end
        end
        got8.delete();
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(model8(a, b, 6'b10_01_01));
            push8(a, b);
        end
        in_valid = 1'b0;
        drain8(1000);
        for (int k = 0; k < 1000; k++) begin
            n_tests++;
            if (k >= got8.size() || got8[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL default_rand[%0d]: got %0d want %0d", k, k < got8.size() ? got8[k] : 16'd0, exp_q[k]);
            end
        end
    endtask

    task automatic test_cfg_midstream();
        logic [15:0] he [4] = '{16'd225, 16'd175, 16'd175, 16'd225};
        write_cfg8(6'b00_00_00);
        got8.delete();
        push8(8'd15, 8'd15);                     // A, exact
        in_valid = 1'b0;
        write_cfg8(6'b10_01_01);
        push8(8'd15, 8'd15);                     // B, new approximate config
        cfg_we = 1'b1; cfg_data = 6'b00_00_00;
        push8(8'd15, 8'd15);                     // C, same-edge write: old config
        cfg_we = 1'b0;
        push8(8'd15, 8'd15);                     // D, exact again
        in_valid = 1'b0;
        drain8(4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (k >= got8.size() || got8[k] !== he[k]) begin
                n_fail++; $display("FAIL cfg_midstream[%0d]: got %0d want %0d", k, k < got8.size() ? got8[k] : 16'd0, he[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  va [5] = '{8'd10, 8'd200, 8'd37, 8'd255, 8'd99};
        logic [7:0]  vb [5] = '{8'd20, 8'd3,   8'd141, 8'd2,  8'd250};
        logic [15:0] ve [5] = '{16'd200, 16'd600, 16'd5217, 16'd510, 16'd24750};
        int idx;
        idx = 0;
        got8.delete();
        for (int c = 0; c < 40; c++) begin
            if (idx == 5 && got8.size() == 5) break;
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (idx < 5);
            if (idx < 5) begin in_a = va[idx]; in_b = vb[idx]; end
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); end
                n_tests++; if (out_valid !== 1'b1 || out_prod !== ve[0]) begin
                    n_fail++; $display("FAIL stall_hold c%0d: got valid=%b prod=%0d want 1/%0d", c, out_valid, out_prod, ve[0]);
                end
            end
            if (c == 7) begin
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: in_ready got %b want 1", in_ready); end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (got8.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got8.size()); end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (k >= got8.size() || got8[k] !== ve[k]) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", k, k < got8.size() ? got8[k] : 16'd0, ve[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        write_cfg8(6'b00_00_00);
        out_ready = 1'b0;
        push8(8'd1, 8'd2);
        push8(8'd3, 8'd4);
        push8(8'd5, 8'd6);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midflight_full: got valid=%b ready=%b want 1/0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_prod !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midflight_async: got valid=%b prod=%0d ready=%b want 0/0/1", out_valid, out_prod, in_ready);
        end
        got8.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        n_tests++; if (got8.size() != 0) begin n_fail++; $display("FAIL midflight_stale: got %0d results want 0", got8.size()); end
        push8(8'd255, 8'd255);
        in_valid = 1'b0;
        drain8(1);
        n_tests++; if (got8.size() < 1 || got8[0] !== 16'd61071) begin
            n_fail++; $display("FAIL midflight_default_cfg: got %0d want 61071", got8.size() > 0 ? got8[0] : 16'd0);
        end
    endtask

    task automatic test_width16();
        logic [15:0] a, b;
        logic [31:0] exp_q[$];
        int t0, t1;
        we16 = 1'b1; cfg16 = '0;
        @(posedge clk); #1;
        we16 = 1'b0;
        got16.delete(); st16.delete();
        push16(16'hFFFF, 16'hFFFF);
        v16 = 1'b0;
        drain16(1);
        n_tests++; if (got16.size() < 1 || got16[0] !== 32'hFFFE0001) begin
            n_fail++; $display("FAIL w16_max: got %h want fffe0001", got16.size() > 0 ? got16[0] : 32'd0);
        end
        got16.delete(); st16.delete();
        t0 = cyc;
        for (int k = 0; k < 100; k++) begin
            a = 16'(k * 517 + 3);
            b = 16'(65535 - k * 263);
            exp_q.push_back({16'h0000, a} * {16'h0000, b});
            push16(a, b);
        end
        t1 = cyc;
        v16 = 1'b0;
        n_tests++; if (t1 - t0 != 100) begin n_fail++; $display("FAIL w16_accept_rate: got %0d cycles want 100", t1 - t0); end
        drain16(100);
        for (int k = 0; k < 100; k++) begin
            n_tests++;
            if (k >= got16.size() || got16[k] !== exp_q[k]) begin
                n_fail++; $display("FAIL w16_stream[%0d]: got %h want %h", k, k < got16.size() ? got16[k] : 32'd0, exp_q[k]);
            end
        end
        n_tests++; if (st16.size() != 100 || st16[st16.size()-1] - st16[0] != 99) begin
            n_fail++; $display("FAIL w16_emit_rate: got %0d results spanning %0d cycles want 100/99",
                               st16.size(), st16.size() > 0 ? st16[st16.size()-1] - st16[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_default();
        test_cfg_midstream();
        test_backpressure();
        test_reset_midflight();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
